avl_gpio_irq: RTL and testbench

- Parametrised Avalon-MM slave GPIO, the successor to the fixed 32-bit gpio peripheral on the core data bus.
- Generalised in pin count and input-synchroniser depth; adds per-pin direction, atomic set/clear/toggle, and edge capture with a maskable level interrupt.
- Sits behind avl_bus_n2n as a slave on the core data bus, with its interrupt routed to the core's external-interrupt input.

---
 rtl/avl_gpio_irq.sv | 135 +++++++++++++
 tb/tb_avl_gpio_irq.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avl_gpio_irq.sv
// Avalon-MM GPIO slave: per-pin direction, atomic set/clear/toggle,
// synchronised inputs and edge capture feeding a maskable level interrupt.
module avl_gpio_irq #(
  parameter int          IO_WIDTH    = 32,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] OUT_RESET   = 32'h0,
  parameter int          ADDR_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rest,
  input  logic [ADDR_WIDTH-1:0] avl_s0_address,
  input  logic [3:0]            avl_s0_byteenable,
  input  logic                  avl_s0_read,
  input  logic                  avl_s0_write,
  input  logic [31:0]           avl_s0_writedata,
  output logic [31:0]           avl_s0_readdata,
  output logic                  avl_s0_readdatavalid,
  output logic                  avl_s0_waitrequest,
  output logic                  irq,
  inout  wire  [IO_WIDTH-1:0]   io
);

  // Bits at and above IO_WIDTH are held at zero in every register.
  localparam logic [31:0] PIN_MASK = 32'hFFFF_FFFF >> (32 - IO_WIDTH);

  logic [31:0] dout_q, dout_d;
  logic [31:0] dir_q, dir_d;
  logic [31:0] ien_q, ien_d;
  logic [31:0] er_q, er_d;
  logic [31:0] ef_q, ef_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] prev_q;
  logic [31:0] sync_q [SYNC_STAGES];
  logic [31:0] rdata_q;
  logic        rvalid_q;
  logic        irq_q;

  logic [3:0]  word;
  logic [31:0] lane_mask, wr_mask, wr_bits, w1c;
  logic [31:0] pad_in, sync_w, edge_set, rd_mux;
  logic        unused_addr;

  assign word        = avl_s0_address[5:2];
  assign unused_addr = ^avl_s0_address[1:0];
  assign lane_mask   = {{8{avl_s0_byteenable[3]}}, {8{avl_s0_byteenable[2]}},
                        {8{avl_s0_byteenable[1]}}, {8{avl_s0_byteenable[0]}}};
  assign wr_mask     = lane_mask & PIN_MASK;
  assign wr_bits     = avl_s0_writedata & wr_mask;

  always_comb begin
    pad_in = '0;
    pad_in[IO_WIDTH-1:0] = io;
  end

  assign sync_w   = sync_q[SYNC_STAGES-1];
  assign edge_set = ((sync_w & ~prev_q & er_q) | (~sync_w & prev_q & ef_q)) & PIN_MASK;

  always_comb begin
    dout_d = dout_q;
    dir_d  = dir_q;
    ien_d  = ien_q;
    er_d   = er_q;
    ef_d   = ef_q;
    w1c    = '0;
    if (avl_s0_write) begin
      case (word)
        4'd0:    dout_d = (dout_q & ~wr_mask) | wr_bits;
        4'd1:    dir_d  = (dir_q & ~wr_mask) | wr_bits;
        4'd3:    dout_d = dout_q | wr_bits;
        4'd4:    dout_d = dout_q & ~wr_bits;
        4'd5:    dout_d = dout_q ^ wr_bits;
        4'd6:    ien_d  = (ien_q & ~wr_mask) | wr_bits;
        4'd7:    er_d   = (er_q & ~wr_mask) | wr_bits;
        4'd8:    ef_d   = (ef_q & ~wr_mask) | wr_bits;
        4'd9:    w1c    = wr_bits;
        default: ;
      endcase
    end
    // A capture in the same cycle as a clear keeps the bit set.
    pend_d = (pend_q & ~w1c) | edge_set;
  end

  always_comb begin
    rd_mux = '0;
    case (word)
      4'd0:    rd_mux = dout_q;
      4'd1:    rd_mux = dir_q;
      4'd2:    rd_mux = sync_w;
      4'd6:    rd_mux = ien_q;
      4'd7:    rd_mux = er_q;
      4'd8:    rd_mux = ef_q;
      4'd9:    rd_mux = pend_q;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      dout_q   <= OUT_RESET & PIN_MASK;
      dir_q    <= '0;
      ien_q    <= '0;
      er_q     <= '0;
      ef_q     <= '0;
      pend_q   <= '0;
      prev_q   <= '0;
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      dout_q   <= dout_d;
      dir_q    <= dir_d;
      ien_q    <= ien_d;
      er_q     <= er_d;
      ef_q     <= ef_d;
      pend_q   <= pend_d;
      prev_q   <= sync_w;
      sync_q[0] <= pad_in & PIN_MASK;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      if (avl_s0_read) rdata_q <= rd_mux;
      rvalid_q <= avl_s0_read;
      irq_q    <= |(pend_q & ien_q);
    end
  end

  for (genvar i = 0; i < IO_WIDTH; i++) begin : g_pad
    assign io[i] = dir_q[i] ? dout_q[i] : 1'bz;
  end

  assign avl_s0_readdata      = rdata_q;
  assign avl_s0_readdatavalid = rvalid_q;
  assign avl_s0_waitrequest   = 1'b0;
  assign irq                  = irq_q;

endmodule

// File: tb/tb_avl_gpio_irq.sv
// Bench for avl_gpio_irq: a 32-pin and an 8-pin instance share one bus;
// expectations come from a register/pad-history model held in the bench.
module tb_avl_gpio_irq;

  localparam int          SS    = 2;
  localparam int          NC    = 300;
  localparam int          OFF   = SS + 1;
  localparam logic [31:0] RST32 = 32'hC3C3_0001;
  localparam logic [31:0] RST8  = 32'h0000_015A;

  logic        clk = 1'b0;
  logic        rest = 1'b1;
  logic [5:0]  addr = '0;
  logic [3:0]  be = '0;
  logic        rd = 1'b0, wr = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata, rdata8;
  logic        rvalid, rvalid8, wreq, wreq8, irq, irq8;
  wire  [31:0] io;
  wire  [7:0]  io8;
  logic [31:0] pad_oe = '0, pad_val = '0;
  logic [7:0]  pad8_oe = '0, pad8_val = '0;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_out, m_dir, m_ien, m_er, m_ef, m_pend;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 32; i++) begin : g_tb_pad
    assign io[i] = pad_oe[i] ? pad_val[i] : 1'bz;
  end
  for (genvar i = 0; i < 8; i++) begin : g_tb_pad8
    assign io8[i] = pad8_oe[i] ? pad8_val[i] : 1'bz;
  end

  avl_gpio_irq #(.IO_WIDTH(32), .SYNC_STAGES(SS), .OUT_RESET(RST32), .ADDR_WIDTH(6)) u_dut (
    .clk(clk), .rest(rest), .avl_s0_address(addr), .avl_s0_byteenable(be),
    .avl_s0_read(rd), .avl_s0_write(wr), .avl_s0_writedata(wdata),
    .avl_s0_readdata(rdata), .avl_s0_readdatavalid(rvalid),
    .avl_s0_waitrequest(wreq), .irq(irq), .io(io));

  avl_gpio_irq #(.IO_WIDTH(8), .SYNC_STAGES(SS), .OUT_RESET(RST8), .ADDR_WIDTH(6)) u_dut8 (
    .clk(clk), .rest(rest), .avl_s0_address(addr), .avl_s0_byteenable(be),
    .avl_s0_read(rd), .avl_s0_write(wr), .avl_s0_writedata(wdata),
    .avl_s0_readdata(rdata8), .avl_s0_readdatavalid(rvalid8),
    .avl_s0_waitrequest(wreq8), .irq(irq8), .io(io8));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    m_out = RST32; m_dir = '0; m_ien = '0; m_er = '0; m_ef = '0; m_pend = '0;
  endfunction

  function automatic void model_write(input int w, input logic [31:0] d, input logic [3:0] b);
    logic [31:0] lanes;
    logic [31:0] bits;
    lanes = '0;
    for (int k = 0; k < 4; k++) if (b[k]) lanes[8*k +: 8] = 8'hFF;
    bits = d & lanes;
    case (w)
      0: m_out  = (m_out & ~lanes) | bits;
      1: m_dir  = (m_dir & ~lanes) | bits;
      3: m_out  = m_out | bits;
      4: m_out  = m_out & ~bits;
      5: m_out  = m_out ^ bits;
      6: m_ien  = (m_ien & ~lanes) | bits;
      7: m_er   = (m_er & ~lanes) | bits;
      8: m_ef   = (m_ef & ~lanes) | bits;
      9: m_pend = m_pend & ~bits;
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input int w);
    case (w)
      0: return m_out;
      1: return m_dir;
      6: return m_ien;
      7: return m_er;
      8: return m_ef;
      9: return m_pend;
      default: return 32'h0;
    endcase
  endfunction

  task automatic bus_write(input int w, input logic [31:0] d, input logic [3:0] b);
    addr = 6'(w * 4); wdata = d; be = b; wr = 1'b1;
    tick();
    wr = 1'b0;
    model_write(w, d, b);
  endtask

  task automatic bus_read(input int w, output logic [31:0] d, output logic v,
                          output logic [31:0] d8, output logic v8);
    addr = 6'(w * 4); rd = 1'b1;
    tick();
    d = rdata; v = rvalid; d8 = rdata8; v8 = rvalid8;
    rd = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d, d8, e, e8;
    logic v, v8;
    pad_oe = '1; pad_val = '0; pad8_oe = '1; pad8_val = '0;
    rest = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b0 || rvalid !== 1'b0 || irq8 !== 1'b0 || rvalid8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs irq=%b rvalid=%b irq8=%b rvalid8=%b, all must be 0",
               irq, rvalid, irq8, rvalid8);
    end
    rest = 1'b0;
    model_reset();
    tick(); tick();
    for (int w = 0; w < 16; w++) begin
      bus_read(w, d, v, d8, v8);
      e  = (w == 0) ? RST32 : 32'h0;
      e8 = (w == 0) ? 32'h0000_005A : 32'h0;
      checks++;
      if (v !== 1'b1 || d !== e) begin
        errors++;
        $display("FAIL reset_read32 w%0d got v=%b d=%h exp v=1 d=%h", w, v, d, e);
      end
      checks++;
      if (v8 !== 1'b1 || d8 !== e8) begin
        errors++;
        $display("FAIL reset_read8 w%0d got v=%b d=%h exp v=1 d=%h", w, v8, d8, e8);
      end
    end
    tick();
    checks++;
    if (rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rvalid_single_pulse got %b exp 0", rvalid);
    end
  endtask

  task automatic test_setclr();
    logic [31:0] d, d8, upper;
    logic v, v8;
    logic [7:0] exp_io [4];
    exp_io = '{8'hA5, 8'hA7, 8'h27, 8'h28};
    upper = $urandom & 32'hFFFF_FF00;
    pad_oe = 32'hFFFF_FF00; pad_val = upper;
    bus_write(1, 32'h0000_00FF, 4'hF);
    bus_write(0, 32'h0000_00A5, 4'hF);
    checks++;
    if (io[7:0] !== exp_io[0]) begin errors++; $display("FAIL io_after_data_out got %h exp %h", io[7:0], exp_io[0]); end
    bus_write(3, 32'h0000_0002, 4'hF);
    checks++;
    if (io[7:0] !== exp_io[1]) begin errors++; $display("FAIL io_after_set got %h exp %h", io[7:0], exp_io[1]); end
    bus_write(4, 32'h0000_0080, 4'hF);
    checks++;
    if (io[7:0] !== exp_io[2]) begin errors++; $display("FAIL io_after_clr got %h exp %h", io[7:0], exp_io[2]); end
    bus_write(5, 32'h0000_000F, 4'hF);
    checks++;
    if (io[7:0] !== exp_io[3]) begin errors++; $display("FAIL io_after_tgl got %h exp %h", io[7:0], exp_io[3]); end
    checks++;
    if (io[31:8] !== upper[31:8]) begin errors++; $display("FAIL io_inputs_undriven got %h exp %h", io[31:8], upper[31:8]); end
    tick();
    bus_read(2, d, v, d8, v8);
    checks++;
    if (d !== (upper | 32'h27)) begin errors++; $display("FAIL data_in_early got %h exp %h", d, upper | 32'h27); end
    bus_read(2, d, v, d8, v8);
    checks++;
    if (d !== (upper | 32'h28)) begin errors++; $display("FAIL data_in_latency got %h exp %h", d, upper | 32'h28); end
    bus_read(3, d, v, d8, v8);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL wo_reads_zero got %h exp 0", d); end
    bus_read(0, d, v, d8, v8);
    checks++;
    if (d !== m_out || m_out !== 32'h28) begin errors++; $display("FAIL data_out_28 got %h exp %h", d, 32'h28); end
    tick(); tick();
    checks++;
    if (rdata !== 32'h28 || rvalid !== 1'b0) begin
      errors++; $display("FAIL readdata_hold got %h v=%b exp 00000028 v=0", rdata, rvalid);
    end
  endtask

  task automatic test_byteenable();
    logic [31:0] d, d8, dw;
    logic v, v8;
    int wl [7];
    int w, rw;
    logic [3:0] b;
    wl = '{0, 3, 4, 5, 6, 7, 8};
    bus_write(0, 32'h1234_5678, 4'hF);
    addr = 6'd0; rd = 1'b1; wr = 1'b1; wdata = 32'hFFFF_FFFF; be = 4'b0100;
    tick();
    rd = 1'b0; wr = 1'b0;
    model_write(0, 32'hFFFF_FFFF, 4'b0100);
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h1234_5678) begin
      errors++; $display("FAIL same_cycle_rw got v=%b d=%h exp v=1 d=12345678", rvalid, rdata);
    end
    bus_read(0, d, v, d8, v8);
    checks++;
    if (d !== 32'h12FF_5678) begin errors++; $display("FAIL byteenable_lane2 got %h exp 12ff5678", d); end
    for (int i = 0; i < 40; i++) begin
      w  = wl[$urandom_range(0, 6)];
      dw = $urandom;
      b  = 4'($urandom_range(0, 15));
      bus_write(w, dw, b);
      rw = (w >= 3 && w <= 5) ? 0 : w;
      bus_read(rw, d, v, d8, v8);
      checks++;
      if (v !== 1'b1 || d !== model_read(rw)) begin
        errors++; $display("FAIL rand_be it%0d w%0d be=%b got %h exp %h", i, w, b, d, model_read(rw));
      end
    end
    bus_write(6, 32'h0, 4'hF);
    bus_write(7, 32'h0, 4'hF);
    bus_write(8, 32'h0, 4'hF);
    repeat (5) tick();
    bus_write(9, 32'hFFFF_FFFF, 4'hF);
  endtask

  task automatic test_hiz();
    logic [31:0] d, d8, pv;
    logic v, v8;
    bus_write(1, 32'h0, 4'hF);
    bus_write(0, $urandom, 4'hF);
    pv = ~m_out;
    pad_oe = '1; pad_val = pv;
    repeat (3) tick();
    bus_read(2, d, v, d8, v8);
    checks++;
    if (d !== pv) begin errors++; $display("FAIL hiz_input_readback got %h exp %h", d, pv); end
  endtask

  task automatic test_edge_irq();
    logic [31:0] d, d8;
    logic v, v8;
    pad_val = '0;
    repeat (4) tick();
    bus_write(9, 32'hFFFF_FFFF, 4'hF);
    bus_write(8, 32'h0, 4'hF);
    bus_write(7, 32'h1, 4'hF);
    bus_write(6, 32'h1, 4'hF);
    tick(); tick();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle got %b exp 0", irq); end
    pad_val[0] = 1'b1;
    tick();
    tick();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_too_early got %b exp 0", irq); end
    addr = 6'(9 * 4); rd = 1'b1;
    tick();
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h0 || irq !== 1'b0) begin
      errors++; $display("FAIL pend_t2 got v=%b d=%h irq=%b exp v=1 d=0 irq=0", rvalid, rdata, irq);
    end
    tick();
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h1 || irq !== 1'b1) begin
      errors++; $display("FAIL pend_t3_irq_t4 got v=%b d=%h irq=%b exp v=1 d=1 irq=1", rvalid, rdata, irq);
    end
    rd = 1'b0;
    tick();
    checks++;
    if (rvalid !== 1'b0 || irq !== 1'b1) begin
      errors++; $display("FAIL irq_held got v=%b irq=%b exp v=0 irq=1", rvalid, irq);
    end
    bus_write(9, 32'h1, 4'hF);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_w1c_n1 got %b exp 1", irq); end
    tick();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_w1c_n2 got %b exp 0", irq); end
    pad_val[0] = 1'b0;
    repeat (5) tick();
    bus_read(9, d, v, d8, v8);
    checks++;
    if (d !== 32'h0 || irq !== 1'b0) begin errors++; $display("FAIL fall_disabled got pend=%h irq=%b exp 0 0", d, irq); end
    pad_val[1] = 1'b1;
    repeat (5) tick();
    bus_write(7, 32'h3, 4'hF);
    repeat (4) tick();
    bus_read(9, d, v, d8, v8);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL no_retroactive got %h exp 0", d); end
    m_pend = '0;
  endtask

  task automatic test_w1c_race();
    logic [31:0] d, d8;
    logic v, v8;
    pad_val[0] = 1'b1;
    repeat (6) tick();
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL race_setup_irq got %b exp 1", irq); end
    pad_val[0] = 1'b0;
    repeat (4) tick();
    pad_val[0] = 1'b1;
    tick(); tick();
    addr = 6'(9 * 4); wdata = 32'h1; be = 4'hF; wr = 1'b1;
    tick();
    wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL race_irq_stays c%0d got %b exp 1", i, irq); end
      tick();
    end
    bus_read(9, d, v, d8, v8);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL race_set_wins got %h exp 1", d); end
    bus_write(9, 32'h1, 4'hF);
    tick();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL race_cleanup got %b exp 0", irq); end
    m_pend = '0;
  endtask

  task automatic test_random_edges();
    logic [31:0] d, d8, ph [NC + OFF], now_v, before_v, mp, w1c;
    logic mirq, mirq_next, v, v8;
    bus_write(7, $urandom, 4'hF);
    bus_write(8, $urandom, 4'hF);
    bus_write(6, $urandom, 4'hF);
    repeat (4) tick();
    bus_write(9, 32'hFFFF_FFFF, 4'hF);
    tick(); tick();
    for (int i = 0; i < OFF; i++) ph[i] = pad_val;
    mp = '0; mirq = 1'b0;
    for (int c = 0; c < NC; c++) begin
      checks++;
      if (irq !== mirq) begin errors++; $display("FAIL rand_irq c%0d got %b exp %b", c, irq, mirq); end
      if ($urandom_range(0, 2) == 0) pad_val = pad_val ^ ($urandom & $urandom & $urandom);
      ph[c + OFF] = pad_val;
      w1c = '0;
      if ($urandom_range(0, 7) == 0) begin
        w1c = $urandom;
        addr = 6'(9 * 4); wdata = w1c; be = 4'hF; wr = 1'b1;
      end else begin
        wr = 1'b0;
      end
      // A pad level reaches the edge detector SS cycles after it is driven.
      now_v    = ph[c + 1];
      before_v = ph[c];
      mirq_next = |(mp & m_ien);
      mp = (mp & ~w1c) | (now_v & ~before_v & m_er) | (~now_v & before_v & m_ef);
      mirq = mirq_next;
      tick();
    end
    wr = 1'b0;
    bus_read(9, d, v, d8, v8);
    checks++;
    if (d !== mp) begin errors++; $display("FAIL rand_pend got %h exp %h", d, mp); end
    m_pend = mp;
  endtask

  task automatic test_width8();
    logic [31:0] d, d8, e, e8;
    logic v, v8;
    pad_oe = '0; pad8_oe = '0;
    bus_write(1, 32'hFFFF_FFFF, 4'hF);
    bus_write(6, 32'hFFFF_FFFF, 4'hF);
    bus_write(0, 32'hFFFF_FFFF, 4'hF);
    bus_read(1, d, v, d8, v8);
    checks++;
    if (d8 !== 32'h0000_00FF || d !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL width_dir got d8=%h d=%h exp 000000ff ffffffff", d8, d);
    end
    bus_read(6, d, v, d8, v8);
    checks++;
    if (d8 !== 32'h0000_00FF || d !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL width_irq_en got d8=%h d=%h exp 000000ff ffffffff", d8, d);
    end
    bus_read(0, d, v, d8, v8);
    checks++;
    if (d8 !== 32'h0000_00FF) begin errors++; $display("FAIL width_data_out got %h exp 000000ff", d8); end
    addr = 6'd0; rd = 1'b1;
    tick();
    rd = 1'b0;
    #2 rest = 1'b1;
    #1;
    checks++;
    if (rvalid !== 1'b0 || rvalid8 !== 1'b0 || irq !== 1'b0 || irq8 !== 1'b0) begin
      errors++; $display("FAIL reset_mid_read got rv=%b rv8=%b irq=%b irq8=%b exp all 0",
                         rvalid, rvalid8, irq, irq8);
    end
    pad_oe = '1; pad_val = '0; pad8_oe = '1; pad8_val = '0;
    repeat (2) @(posedge clk);
    #1 rest = 1'b0;
    model_reset();
    tick();
    checks++;
    if (rvalid !== 1'b0 || rvalid8 !== 1'b0) begin
      errors++; $display("FAIL no_valid_after_reset got rv=%b rv8=%b exp 0 0", rvalid, rvalid8);
    end
    tick();
    for (int w = 0; w < 16; w++) begin
      bus_read(w, d, v, d8, v8);
      e  = (w == 0) ? RST32 : 32'h0;
      e8 = (w == 0) ? 32'h0000_005A : 32'h0;
      checks++;
      if (v !== 1'b1 || v8 !== 1'b1 || d !== e || d8 !== e8) begin
        errors++; $display("FAIL rereset_w%0d got v=%b d=%h v8=%b d8=%h exp %h %h", w, v, d, v8, d8, e, e8);
      end
    end
  endtask

  initial begin
    test_reset();
    test_setclr();
    test_byteenable();
    test_hiz();
    test_edge_irq();
    test_w1c_race();
    test_random_edges();
    test_width8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
